// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter.
// Packs DIGITS BCD digits onto bcd, most significant digit in the top nibble.
// Optional build macro: BIN2BCD_SATURATE_EN. When it is defined, an
// overflowing result shows as all nines. Otherwise bcd shows the value
// mod 10^DIGITS.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; bcd/ovf hold the last result
// ST_SHIFT | one add-3/shift step per cycle, IN_WIDTH steps in total
// ST_DONE  | new bcd/ovf visible, done pulses for one cycle
module bin2bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   din,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  localparam int SDIG = (IN_WIDTH + 2) / 3;
  localparam int SW   = 4 * SDIG;
  localparam int CW   = $clog2(IN_WIDTH + 1);
  localparam int EW   = 4 * (SDIG + DIGITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [IN_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  logic [SW-1:0]       adj;
  logic [SW-1:0]       shifted;
  logic [EW-1:0]       ext;
  logic [4*DIGITS-1:0] low_digits;
  logic                hi_nz;

  // One add-3/shift step on the scratch digits, plus the result slices
  // taken from it. Zero padding handles DIGITS larger than SDIG.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < SDIG; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted    = {adj[SW-2:0], sr_q[IN_WIDTH-1]};
    ext        = {{(4*DIGITS){1'b0}}, shifted};
    low_digits = ext[4*DIGITS-1:0];
    hi_nz      = |ext[EW-1:4*DIGITS];
  end

  // Next-state and datapath updates of the conversion sequencer.
  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d      = din;
          scratch_d = '0;
          cnt_d     = CW'(IN_WIDTH);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = shifted;
        sr_d      = {sr_q[IN_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        // Result is loaded on the last shift edge so it is visible
        // during the DONE cycle together with the done pulse.
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          ovf_d   = hi_nz;
`ifdef BIN2BCD_SATURATE_EN
          bcd_d   = hi_nz ? {DIGITS{4'h9}} : low_digits;
`else
          bcd_d   = low_digits;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      scratch_q <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] din;
  logic [15:0] bcd;
  logic        ovf;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_bcd = 16'h0;
  logic        exp_ovf = 1'b0;

  bin2bcd_seq #(.IN_WIDTH(16), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .bcd(bcd), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_bcd(input int v);
    int m;
    m = v % 10000;
`ifdef BIN2BCD_SATURATE_EN
    if (v >= 10000) return 16'h9999;
`endif
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion of v; optionally pulse start with pdin at cycle pcyc.
  task automatic run_conv(input int v, input int pcyc, input logic [15:0] pdin);
    logic [15:0] nb;
    logic        no;
    nb = model_bcd(v);
    no = (v >= 10000);
    start = 1'b1;
    din   = 16'(v);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k <= 17) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL conv_busy v=%0d cyc=%0d got=%b exp=1", v, k, busy);
        end
      end
      if (k < 17) begin
        n_checks++;
        if (done !== 1'b0 || bcd !== exp_bcd || ovf !== exp_ovf) begin
          n_fail++;
          $display("FAIL conv_hold v=%0d cyc=%0d got done=%b bcd=%h ovf=%b exp done=0 bcd=%h ovf=%b",
                   v, k, done, bcd, ovf, exp_bcd, exp_ovf);
        end
      end else if (k == 17) begin
        n_checks++;
        if (done !== 1'b1 || bcd !== nb || ovf !== no) begin
          n_fail++;
          $display("FAIL conv_result v=%0d got done=%b bcd=%h ovf=%b exp done=1 bcd=%h ovf=%b",
                   v, done, bcd, ovf, nb, no);
        end
        exp_bcd = nb;
        exp_ovf = no;
      end else begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL conv_idle v=%0d got busy=%b done=%b exp 0 0", v, busy, done);
        end
      end
      start = (k == pcyc);
      din   = (k == pcyc) ? pdin : 16'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din = 16'h0;
    tick(); tick();
    n_checks++;
    if (bcd !== 16'h0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got bcd=%h ovf=%b busy=%b done=%b exp all 0", bcd, ovf, busy, done);
    end
    reset = 1'b0;
    tick();
    exp_bcd = 16'h0; exp_ovf = 1'b0;
  endtask

  task automatic test_directed();
    run_conv(1234, -1, 16'h0);
    run_conv(0, -1, 16'h0);
    run_conv(9999, -1, 16'h0);
    run_conv(65535, -1, 16'h0);
    run_conv(10000, -1, 16'h0);
  endtask

  task automatic test_ignore_start();
    run_conv(1234, 5, 16'd42);
    run_conv(4321, 3, 16'd7);
  endtask

  task automatic test_reset_abort();
    run_conv(1234, -1, 16'h0);
    start = 1'b1; din = 16'd4321;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 1'b0; din = 16'($urandom);
      n_checks++;
      if (done !== 1'b0 || bcd !== 16'h1234) begin
        n_fail++; $display("FAIL abort_pre cyc=%0d got done=%b bcd=%h exp 0 1234", k, done, bcd);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (bcd !== 16'h0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset got bcd=%h ovf=%b busy=%b done=%b exp all 0", bcd, ovf, busy, done);
    end
    exp_bcd = 16'h0; exp_ovf = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_quiet got done=%b busy=%b exp 0 0", done, busy);
      end
    end
    run_conv(4321, -1, 16'h0);
  endtask

  task automatic test_reset_start_same();
    reset = 1'b1; start = 1'b1; din = 16'd99;
    tick();
    reset = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bcd !== 16'h0) begin
      n_fail++; $display("FAIL reset_start got busy=%b bcd=%h exp 0 0000", busy, bcd);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    exp_bcd = 16'h0; exp_ovf = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; din = 16'd7;
    for (int k = 1; k <= 54; k++) begin
      tick();
      n_checks++;
      if (done !== (k % 18 == 17)) begin
        n_fail++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, done, (k % 18 == 17));
      end
      n_checks++;
      if (busy !== (k % 18 != 0)) begin
        n_fail++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", k, busy, (k % 18 != 0));
      end
      if (k % 18 == 17) begin
        n_checks++;
        if (bcd !== 16'h0007 || ovf !== 1'b0) begin
          n_fail++; $display("FAIL b2b_bcd cyc=%0d got bcd=%h ovf=%b exp 0007 0", k, bcd, ovf);
        end
      end
    end
    start = 1'b0;
    tick(); tick(); tick();
    exp_bcd = 16'h0007; exp_ovf = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12000));
      run_conv(v, int'($urandom_range(0, 20)), 16'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = 16'h0;
    #1;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_reset_start_same();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
